// File: rtl/apu_pkg.sv
// Shared APU definitions: waveform selector and the length-counter lookup table
// used by the pulse, noise and wave channels.
package apu_pkg;

  typedef enum logic [1:0] {
    WAVE_TRI  = 2'd0,
    WAVE_SAW  = 2'd1,
    WAVE_RAMP = 2'd2,
    WAVE_SQR  = 2'd3
  } wave_mode_t;

  localparam int unsigned LEN_IDX_W = 5;
  localparam int unsigned LEN_CNT_W = 8;

  localparam logic [LEN_CNT_W-1:0] LEN_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

  function automatic logic [LEN_CNT_W-1:0] len_lookup(input logic [LEN_IDX_W-1:0] idx);
    return LEN_TABLE[idx];
  endfunction

endpackage

// File: rtl/length_counter.sv
// APU length counter: table-loaded down-counter clocked by the half-frame tick.
// A load in the same cycle as a half tick takes priority over the decrement.
module length_counter
  import apu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 disable_l,
  input  logic                 halt,
  input  logic                 half_clk_en,
  input  logic                 load,
  input  logic [LEN_IDX_W-1:0] load_idx,
  output logic                 non_zero
);

  logic [LEN_CNT_W-1:0] count;
  logic [LEN_CNT_W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (!disable_l) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = len_lookup(load_idx);
    end else if (half_clk_en && !halt && (count != '0)) begin
      count_nxt = count - LEN_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      count    <= '0;
      non_zero <= 1'b0;
    end else begin
      count    <= count_nxt;
      non_zero <= (count_nxt != '0);
    end
  end

endmodule

// File: rtl/wave_timer.sv
// Period timer: holds the period register and a down-counter that reloads from it
// and emits a single-cycle tick each time it expires on a CPU tick.
module wave_timer #(
  parameter int unsigned TIMER_W = 11
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               cpu_clk_en,
  input  logic               timer_load,
  input  logic [TIMER_W-1:0] timer_load_data,
  output logic [TIMER_W-1:0] period,
  output logic               tick_c
);

  logic [TIMER_W-1:0] count;

  assign tick_c = cpu_clk_en && (count == '0);

  // Loading the period never disturbs the running count; it takes effect on the next reload.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      period <= '0;
      count  <= '0;
    end else begin
      if (timer_load) begin
        period <= timer_load_data;
      end
      if (cpu_clk_en) begin
        count <= (count == '0) ? period : count - TIMER_W'(1);
      end
    end
  end

endmodule

// File: rtl/wave_channel.sv
// Generalised triangle channel: linear/length gating, period timer, sequencer and
// run-time selectable waveform decode (triangle, saw, ramp-down, square).
module wave_channel
  import apu_pkg::*;
#(
  parameter int unsigned SEQ_LEN_LOG2 = 5,
  parameter int unsigned SAMPLE_W     = 4,
  parameter int unsigned TIMER_W      = 11,
  parameter int unsigned LINEAR_W     = 7
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    cpu_clk_en,
  input  logic                    quarter_clk_en,
  input  logic                    half_clk_en,
  input  logic                    disable_l,
  input  logic                    length_halt,
  input  logic                    linear_load,
  input  logic [LINEAR_W-1:0]     linear_load_data,
  input  logic                    timer_load,
  input  logic [TIMER_W-1:0]      timer_load_data,
  input  logic                    length_load,
  input  logic [LEN_IDX_W-1:0]    length_load_data,
  input  logic                    mode_load,
  input  logic [1:0]              mode_data,
  input  logic                    ultra_mute_en,
  output logic                    length_non_zero,
  output logic [SEQ_LEN_LOG2-1:0] seq_pos,
  output logic [SAMPLE_W-1:0]     out
);

  localparam int unsigned SEQ_LAST = (1 << SEQ_LEN_LOG2) - 1;
  localparam int unsigned SHIFT    = SEQ_LEN_LOG2 - 1 - SAMPLE_W;
  localparam logic [SAMPLE_W-1:0] MAX_SAMPLE = '1;

  logic [TIMER_W-1:0]  period;
  logic                tick_c;
  logic [LINEAR_W-1:0] linear_reload;
  logic [LINEAR_W-1:0] linear_cnt;
  logic                reload_flag;
  wave_mode_t          mode;
  wave_mode_t          pend_mode;
  logic                pend_valid;
  logic                ultra_freeze;
  logic                advance;
  logic                wrap;

  wave_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk             (clk),
    .rst_l           (rst_l),
    .cpu_clk_en      (cpu_clk_en),
    .timer_load      (timer_load),
    .timer_load_data (timer_load_data),
    .period          (period),
    .tick_c          (tick_c)
  );

  length_counter u_length (
    .clk         (clk),
    .rst_l       (rst_l),
    .disable_l   (disable_l),
    .halt        (length_halt),
    .half_clk_en (half_clk_en),
    .load        (length_load),
    .load_idx    (length_load_data),
    .non_zero    (length_non_zero)
  );

  // Linear counter; a load coinciding with a quarter tick reloads the new value and keeps the flag.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      linear_reload <= '0;
      linear_cnt    <= '0;
      reload_flag   <= 1'b0;
    end else begin
      if (linear_load) begin
        linear_reload <= linear_load_data;
      end
      if (quarter_clk_en) begin
        if (linear_load) begin
          linear_cnt <= linear_load_data;
        end else if (reload_flag) begin
          linear_cnt <= linear_reload;
        end else if (linear_cnt != '0) begin
          linear_cnt <= linear_cnt - LINEAR_W'(1);
        end
      end
      if (linear_load) begin
        reload_flag <= 1'b1;
      end else if (quarter_clk_en && !length_halt) begin
        reload_flag <= 1'b0;
      end
    end
  end

  assign ultra_freeze = ultra_mute_en && (period < TIMER_W'(2));
  assign advance      = tick_c && (linear_cnt != '0) && length_non_zero && !ultra_freeze;
  assign wrap         = advance && (seq_pos == SEQ_LEN_LOG2'(SEQ_LAST));

  // Sequencer and mode latch; a pending mode only takes over at the wrap to position 0.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      seq_pos    <= '0;
      mode       <= WAVE_TRI;
      pend_mode  <= WAVE_TRI;
      pend_valid <= 1'b0;
    end else begin
      if (advance) begin
        seq_pos <= wrap ? '0 : seq_pos + SEQ_LEN_LOG2'(1);
      end
      if (wrap && pend_valid) begin
        mode <= pend_mode;
      end
      if (mode_load) begin
        pend_valid <= 1'b1;
        pend_mode  <= wave_mode_t'(mode_data);
      end else if (wrap) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Sample decode from registered state only; the top bit of seq_pos marks the second half.
  always_comb begin
    out = MAX_SAMPLE;
    unique case (mode)
      WAVE_TRI: begin
        if (seq_pos[SEQ_LEN_LOG2-1]) begin
          out = SAMPLE_W'(seq_pos[SEQ_LEN_LOG2-2:0] >> SHIFT);
        end else begin
          out = MAX_SAMPLE - SAMPLE_W'(seq_pos[SEQ_LEN_LOG2-2:0] >> SHIFT);
        end
      end
      WAVE_SAW:  out = SAMPLE_W'(seq_pos >> (SHIFT + 1));
      WAVE_RAMP: out = MAX_SAMPLE - SAMPLE_W'(seq_pos >> (SHIFT + 1));
      WAVE_SQR:  out = seq_pos[SEQ_LEN_LOG2-1] ? '0 : MAX_SAMPLE;
    endcase
  end

endmodule

// File: tb/tb_wave_channel.sv
// Scoreboard bench for wave_channel: directed scenarios plus random traffic, checked
// cycle by cycle against a behavioural channel model kept in the bench.
module tb_wave_channel;

  logic       clk;
  logic       rst_l;
  logic       cpu_clk_en;
  logic       quarter_clk_en;
  logic       half_clk_en;
  logic       disable_l;
  logic       length_halt;
  logic       linear_load;
  logic [6:0] linear_load_data;
  logic       timer_load;
  logic [10:0] timer_load_data;
  logic       length_load;
  logic [4:0] length_load_data;
  logic       mode_load;
  logic [1:0] mode_data;
  logic       ultra_mute_en;
  logic       length_non_zero;
  logic [4:0] seq_pos;
  logic [3:0] out;

  wave_channel dut (
    .clk              (clk),
    .rst_l            (rst_l),
    .cpu_clk_en       (cpu_clk_en),
    .quarter_clk_en   (quarter_clk_en),
    .half_clk_en      (half_clk_en),
    .disable_l        (disable_l),
    .length_halt      (length_halt),
    .linear_load      (linear_load),
    .linear_load_data (linear_load_data),
    .timer_load       (timer_load),
    .timer_load_data  (timer_load_data),
    .length_load      (length_load),
    .length_load_data (length_load_data),
    .mode_load        (mode_load),
    .mode_data        (mode_data),
    .ultra_mute_en    (ultra_mute_en),
    .length_non_zero  (length_non_zero),
    .seq_pos          (seq_pos),
    .out              (out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int smp;
    int pos;
    int lnz;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int tri_tab [32] = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0,
                       0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
  int len_tab [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                       12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

  // Model state
  int m_p, m_t, m_l, m_r, m_flag, m_c, m_pos, m_mode, m_pend, m_pend_v;

  function automatic int wave_of(int mode, int i);
    case (mode)
      0:       return tri_tab[i];
      1:       return i / 2;
      2:       return 15 - i / 2;
      default: return (i < 16) ? 15 : 0;
    endcase
  endfunction

  task automatic model_step();
    bit tick, adv;
    exp_t e;
    if (!rst_l) begin
      m_p = 0; m_t = 0; m_l = 0; m_r = 0; m_flag = 0; m_c = 0;
      m_pos = 0; m_mode = 0; m_pend = 0; m_pend_v = 0;
    end else begin
      tick = cpu_clk_en && (m_t == 0);
      adv  = tick && (m_l != 0) && (m_c != 0) && !(ultra_mute_en && m_p < 2);
      if (cpu_clk_en) m_t = (m_t == 0) ? m_p : m_t - 1;
      if (timer_load) m_p = int'(timer_load_data);
      if (quarter_clk_en) begin
        if (linear_load) m_l = int'(linear_load_data);
        else if (m_flag != 0) m_l = m_r;
        else if (m_l != 0) m_l = m_l - 1;
      end
      if (linear_load) begin
        m_r = int'(linear_load_data);
        m_flag = 1;
      end else if (quarter_clk_en && !length_halt) begin
        m_flag = 0;
      end
      if (!disable_l) m_c = 0;
      else if (length_load) m_c = len_tab[length_load_data];
      else if (half_clk_en && !length_halt && m_c != 0) m_c = m_c - 1;
      if (adv) begin
        if (m_pos == 31) begin
          m_pos = 0;
          if (m_pend_v != 0) begin
            m_mode = m_pend;
            m_pend_v = 0;
          end
        end else begin
          m_pos = m_pos + 1;
        end
      end
      if (mode_load) begin
        m_pend = int'(mode_data);
        m_pend_v = 1;
      end
    end
    e.smp = wave_of(m_mode, m_pos);
    e.pos = m_pos;
    e.lnz = (m_c != 0) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic clear_pulses();
    quarter_clk_en = 1'b0;
    half_clk_en    = 1'b0;
    linear_load    = 1'b0;
    timer_load     = 1'b0;
    length_load    = 1'b0;
    mode_load      = 1'b0;
  endtask

  // Inputs are set before the call; the model predicts the state after the next edge.
  task automatic step();
    model_step();
    @(negedge clk);
    clear_pulses();
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic check(string name, int got, int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: each cycle the DUT presents a sample, compare it with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out", int'(out), e.smp);
        check("seq_pos", int'(seq_pos), e.pos);
        check("length_non_zero", int'(length_non_zero), e.lnz);
      end
    end
  end

  initial begin
    int guard;
    rst_l = 1'b0; cpu_clk_en = 1'b0; disable_l = 1'b1; length_halt = 1'b1;
    linear_load_data = '0; timer_load_data = '0; length_load_data = '0;
    mode_data = '0; ultra_mute_en = 1'b0;
    clear_pulses();
    m_p = 0; m_t = 0; m_l = 0; m_r = 0; m_flag = 0; m_c = 0;
    m_pos = 0; m_mode = 0; m_pend = 0; m_pend_v = 0;
    @(negedge clk);

    // Reset, then triangle at P=0
    run(2);
    rst_l = 1'b1; cpu_clk_en = 1'b1;
    linear_load = 1'b1; linear_load_data = 7'h7F; quarter_clk_en = 1'b1;
    step();
    length_load = 1'b1; length_load_data = 5'd1;
    step();
    run(70);

    // Period 3, then reload to 7 mid-count
    timer_load = 1'b1; timer_load_data = 11'd3;
    step();
    run(41);
    timer_load = 1'b1; timer_load_data = 11'd7;
    step();
    run(60);

    // Mode change requested mid-sequence
    timer_load = 1'b1; timer_load_data = 11'd0;
    step();
    guard = 0;
    while (m_pos != 10 && guard < 200) begin
      step();
      guard++;
    end
    mode_load = 1'b1; mode_data = 2'd1;
    step();
    run(80);

    // Disable, then linear counter runs out
    disable_l = 1'b0;
    run(10);
    disable_l = 1'b1; length_load = 1'b1; length_load_data = 5'd1;
    step();
    length_halt = 1'b0;
    linear_load = 1'b1; linear_load_data = 7'd2; quarter_clk_en = 1'b1;
    step();
    run(3);
    quarter_clk_en = 1'b1; step(); run(3);
    quarter_clk_en = 1'b1; step(); run(3);
    quarter_clk_en = 1'b1; step();
    run(20);
    length_halt = 1'b1;
    linear_load = 1'b1; linear_load_data = 7'h7F; quarter_clk_en = 1'b1;
    step();

    // Ultrasonic freeze
    timer_load = 1'b1; timer_load_data = 11'd1; ultra_mute_en = 1'b1;
    step();
    run(20);
    ultra_mute_en = 1'b0;
    run(20);

    // Simultaneous events
    length_halt = 1'b0;
    length_load = 1'b1; length_load_data = 5'd3; half_clk_en = 1'b1;
    step();
    half_clk_en = 1'b1; step();
    half_clk_en = 1'b1; step();
    run(2);
    length_load = 1'b1; length_load_data = 5'd1; half_clk_en = 1'b1;
    step();
    linear_load = 1'b1; linear_load_data = 7'h30; quarter_clk_en = 1'b1;
    step();
    length_halt = 1'b1;
    linear_load = 1'b1; linear_load_data = 7'h7F; quarter_clk_en = 1'b1;
    mode_load = 1'b1; mode_data = 2'd2;
    step();
    run(45);
    rst_l = 1'b0;
    step();
    rst_l = 1'b1;
    run(5);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      rst_l          = ($urandom_range(0, 399) != 0);
      cpu_clk_en     = ($urandom_range(0, 3) != 0);
      quarter_clk_en = ($urandom_range(0, 19) == 0);
      half_clk_en    = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) disable_l = ~disable_l;
      if (!disable_l && $urandom_range(0, 9) == 0) disable_l = 1'b1;
      if ($urandom_range(0, 49) == 0) length_halt = ~length_halt;
      if ($urandom_range(0, 99) == 0) ultra_mute_en = ~ultra_mute_en;
      linear_load      = ($urandom_range(0, 39) == 0);
      linear_load_data = 7'($urandom_range(0, 127));
      timer_load       = ($urandom_range(0, 49) == 0);
      timer_load_data  = 11'($urandom_range(0, 4));
      length_load      = ($urandom_range(0, 29) == 0);
      length_load_data = 5'($urandom_range(0, 31));
      mode_load        = ($urandom_range(0, 49) == 0);
      mode_data        = 2'($urandom_range(0, 3));
      step();
    end

    clear_pulses();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
